// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction-fetch requester (i*), data requester (d*)
// and the shared memory port (m*).
//   slave  : arbiter view (requests in, responses and memory command out)
//   master : environment view (requesters and memory model)
interface mem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              iread;
    logic [DATA_W-1:0] iaddr;
    logic [DATA_W-1:0] irdata;
    logic              ibusywait;

    logic [3:0]        dread;
    logic [2:0]        dwrite;
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] dwdata;
    logic [DATA_W-1:0] drdata;
    logic              dbusywait;

    logic [3:0]        mread;
    logic [2:0]        mwrite;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;
    logic [DATA_W-1:0] mrdata;
    logic              mbusywait;

    modport slave (
        input  iread, iaddr, dread, dwrite, daddr, dwdata, mrdata, mbusywait,
        output irdata, ibusywait, drdata, dbusywait, mread, mwrite, maddr, mwdata
    );

    modport master (
        output iread, iaddr, dread, dwrite, daddr, dwdata, mrdata, mbusywait,
        input  irdata, ibusywait, drdata, dbusywait, mread, mwrite, maddr, mwdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a data port share
// one memory. A granted request is latched and presented to memory until the
// memory drops mbusywait; read data is then captured and the requester sees its
// busywait low for exactly one cycle.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : mem_arbiter_if.slave (requester and memory signals)
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. Without it the data side always wins a tie.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate pending requests
// BUSY_I | instruction fetch presented to memory
// BUSY_D | data access presented to memory
// RESP_I | fetch done, ibusywait released for one cycle
// RESP_D | data access done, dbusywait released for one cycle
module mem_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic [3:0] IFETCH_RD = 4'b1010;

    state_t            state_q, state_d;
    logic [3:0]        cmd_rd_q, cmd_rd_d;
    logic [2:0]        cmd_wr_q, cmd_wr_d;
    logic [DATA_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;

    logic i_pend;
    logic d_pend;
    logic pick_i;
    logic in_busy;

    assign i_pend = bus.iread;
    assign d_pend = (bus.dread != 4'd0) || (bus.dwrite != 3'd0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data side was granted last; reset value 0 lets the data side win the first tie.
    logic last_d_q, last_d_d;
    assign pick_i = i_pend && (!d_pend || last_d_q);
`else
    assign pick_i = i_pend && !d_pend;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_i) begin
                    state_d     = BUSY_I;
                    cmd_rd_d    = IFETCH_RD;
                    cmd_wr_d    = 3'd0;
                    cmd_addr_d  = bus.iaddr;
                    cmd_wdata_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b0;
`endif
                end else if (d_pend) begin
                    state_d     = BUSY_D;
                    cmd_rd_d    = bus.dread;
                    cmd_wr_d    = bus.dwrite;
                    cmd_addr_d  = bus.daddr;
                    cmd_wdata_d = bus.dwdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b1;
`endif
                end
            end
            // BUSY is always entered on a clock edge, so any later edge already has
            // a full cycle behind it: mbusywait alone decides completion.
            BUSY_I: begin
                if (!bus.mbusywait) begin
                    irdata_d = bus.mrdata;
                    state_d  = RESP_I;
                end
            end
            BUSY_D: begin
                if (!bus.mbusywait) begin
                    if (cmd_rd_q != 4'd0) begin
                        drdata_d = bus.mrdata;
                    end
                    state_d = RESP_D;
                end
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cmd_rd_q    <= '0;
            cmd_wr_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    // Memory command is gated by state so it drops to zero the moment reset hits.
    assign in_busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign bus.mread  = in_busy ? cmd_rd_q    : '0;
    assign bus.mwrite = in_busy ? cmd_wr_q    : '0;
    assign bus.maddr  = in_busy ? cmd_addr_q  : '0;
    assign bus.mwdata = in_busy ? cmd_wdata_q : '0;

    assign bus.irdata    = irdata_q;
    assign bus.drdata    = drdata_q;
    assign bus.ibusywait = i_pend && (state_q != RESP_I);
    assign bus.dbusywait = d_pend && (state_q != RESP_D);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mem_arbiter #(.DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   wait_n = 0;
    int   acc_cnt = 0;
    logic [31:0] exp_irdata = '0;
    logic [31:0] exp_drdata = '0;
    logic        model_last_d = 1'b0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic cmd_t mk_i(input logic [31:0] a);
        return '{rd: 4'b1010, wr: 3'd0, addr: a, wdata: 32'd0};
    endfunction

    function automatic cmd_t mk_d(input logic [3:0] rd, input logic [2:0] wr,
                                  input logic [31:0] a, input logic [31:0] wd);
        return '{rd: rd, wr: wr, addr: a, wdata: wd};
    endfunction

    // Reference tie-break: does the data side win when both request together?
    function automatic logic model_d_wins();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !model_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Memory model: logs each new command, holds mbusywait for wait_n cycles.
    always @(negedge clk) begin
        if (bus.mread != 4'd0 || bus.mwrite != 3'd0) begin
            if (acc_cnt == 0)
                obs_q.push_back(mk_d(bus.mread, bus.mwrite, bus.maddr, bus.mwdata));
            bus.mbusywait = (acc_cnt < wait_n);
            bus.mrdata    = rd_val(bus.maddr);
            acc_cnt++;
        end else begin
            acc_cnt       = 0;
            bus.mbusywait = 1'b0;
            bus.mrdata    = 32'hBAD0_BAD0;
        end
    end

    // Requester drivers: called at a negedge, return the number of sampled
    // busywait-high cycles before release (-1 on timeout).
    task automatic drive_i(input logic [31:0] a, output int hi);
        bus.iread = 1'b1;
        bus.iaddr = a;
        hi = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.ibusywait === 1'b0) begin
                hi = k;
                break;
            end
        end
        bus.iread = 1'b0;
    endtask

    task automatic drive_d(input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] a, input logic [31:0] wd, output int hi);
        bus.dread  = rd;
        bus.dwrite = wr;
        bus.daddr  = a;
        bus.dwdata = wd;
        hi = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.dbusywait === 1'b0) begin
                hi = k;
                break;
            end
        end
        bus.dread  = 4'd0;
        bus.dwrite = 3'd0;
    endtask

    task automatic test_reset();
        bus.iread = 1'b0; bus.iaddr = '0;
        bus.dread = '0; bus.dwrite = '0; bus.daddr = '0; bus.dwdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.mread !== 4'd0 || bus.mwrite !== 3'd0) begin n_err++;
            $display("FAIL reset_mcmd: mread=%h mwrite=%h, want 0/0", bus.mread, bus.mwrite); end
        n_cmp++; if (bus.maddr !== 32'd0 || bus.mwdata !== 32'd0) begin n_err++;
            $display("FAIL reset_mbus: maddr=%h mwdata=%h, want 0/0", bus.maddr, bus.mwdata); end
        n_cmp++; if (bus.irdata !== 32'd0 || bus.drdata !== 32'd0) begin n_err++;
            $display("FAIL reset_rdata: irdata=%h drdata=%h, want 0/0", bus.irdata, bus.drdata); end
        n_cmp++; if (bus.ibusywait !== 1'b0 || bus.dbusywait !== 1'b0) begin n_err++;
            $display("FAIL reset_busy_idle: ibw=%b dbw=%b, want 0/0", bus.ibusywait, bus.dbusywait); end
        bus.iread = 1'b1;
        #1;
        n_cmp++; if (bus.ibusywait !== 1'b1) begin n_err++;
            $display("FAIL reset_busy_pend: ibw=%b, want 1", bus.ibusywait); end
        bus.iread = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_i();
        int hi;
        wait_n = 2;
        exp_q.push_back(mk_i(32'h10));
        model_last_d = 1'b0;
        drive_i(32'h10, hi);
        exp_irdata = rd_val(32'h10);
        n_cmp++; if (hi !== 3) begin n_err++;
            $display("FAIL single_i_latency: busy cycles=%0d, want 3", hi); end
        n_cmp++; if (bus.irdata !== 32'h0050_0093) begin n_err++;
            $display("FAIL single_i_rdata: irdata=%h, want 00500093", bus.irdata); end
        n_cmp++; if (obs_q.size() == 0) begin n_err++;
            $display("FAIL single_i_cmd: no command seen, want %h", exp_q[0]); end
        else if (obs_q[0] !== exp_q[0]) begin n_err++;
            $display("FAIL single_i_cmd: got %h, want %h", obs_q[0], exp_q[0]); end
        void'(exp_q.pop_front()); if (obs_q.size() != 0) void'(obs_q.pop_front());
        @(negedge clk);
        n_cmp++; if (bus.mread !== 4'd0 || bus.ibusywait !== 1'b0) begin n_err++;
            $display("FAIL single_i_idle: mread=%h ibw=%b, want 0/0", bus.mread, bus.ibusywait); end
    endtask

    task automatic test_store();
        int hi;
        cmd_t e, o;
        wait_n = 1;
        exp_q.push_back(mk_d(4'b1000, 3'd0, 32'h40, 32'd0));
        drive_d(4'b1000, 3'd0, 32'h40, 32'd0, hi);
        exp_drdata = rd_val(32'h40);
        model_last_d = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk_d(4'd0, 3'b011, 32'h20, 32'hDEAD_BEEF));
        drive_d(4'd0, 3'b011, 32'h20, 32'hDEAD_BEEF, hi);
        n_cmp++; if (hi !== 2) begin n_err++;
            $display("FAIL store_latency: busy cycles=%0d, want 2", hi); end
        n_cmp++; if (bus.drdata !== exp_drdata) begin n_err++;
            $display("FAIL store_drdata: drdata=%h, want %h", bus.drdata, exp_drdata); end
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++;
                $display("FAIL store_cmd%0d: no command seen, want %h", k, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++;
                    $display("FAIL store_cmd%0d: got %h, want %h", k, o, e); end
            end
        end
        @(negedge clk);
    endtask

    // Both sides request in the same cycle; expected order comes from the tie model.
    task automatic run_pair(input string tag, input int w, input logic [31:0] ia,
                            input logic [31:0] da);
        int hi_i, hi_d, want_i, want_d;
        logic d_first;
        cmd_t e, o;
        wait_n = w;
        d_first = model_d_wins();
        if (d_first) begin
            exp_q.push_back(mk_d(4'b0100, 3'd0, da, 32'd0));
            exp_q.push_back(mk_i(ia));
            want_d = w + 1; want_i = 2 * (w + 1) + 2;
        end else begin
            exp_q.push_back(mk_i(ia));
            exp_q.push_back(mk_d(4'b0100, 3'd0, da, 32'd0));
            want_i = w + 1; want_d = 2 * (w + 1) + 2;
        end
        model_last_d = !d_first;
        fork
            drive_i(ia, hi_i);
            drive_d(4'b0100, 3'd0, da, 32'd0, hi_d);
        join
        exp_irdata = rd_val(ia);
        exp_drdata = rd_val(da);
        n_cmp++; if (hi_i !== want_i || hi_d !== want_d) begin n_err++;
            $display("FAIL %s_busy: ibw cycles=%0d dbw cycles=%0d, want %0d/%0d",
                     tag, hi_i, hi_d, want_i, want_d); end
        n_cmp++; if (bus.irdata !== exp_irdata || bus.drdata !== exp_drdata) begin n_err++;
            $display("FAIL %s_rdata: irdata=%h drdata=%h, want %h/%h",
                     tag, bus.irdata, bus.drdata, exp_irdata, exp_drdata); end
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++;
                $display("FAIL %s_grant%0d: no command seen, want %h", tag, k, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++;
                    $display("FAIL %s_grant%0d: got %h, want %h", tag, k, o, e); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        run_pair("simul", 1, 32'h100, 32'h200);
    endtask

    task automatic test_back_to_back();
        run_pair("b2b0", 0, 32'h104, 32'h204);
        run_pair("b2b1", 1, 32'h108, 32'h208);
        run_pair("b2b2", 2, 32'h10C, 32'h20C);
    endtask

    task automatic test_tie_after_d();
        int hi;
        wait_n = 0;
        exp_q.push_back(mk_d(4'b0010, 3'd0, 32'h300, 32'd0));
        drive_d(4'b0010, 3'd0, 32'h300, 32'd0, hi);
        exp_drdata = rd_val(32'h300);
        model_last_d = 1'b1;
        n_cmp++; if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin n_err++;
            $display("FAIL tie_pre_cmd: seen=%0d, want %h", obs_q.size(), exp_q[0]); end
        void'(exp_q.pop_front()); if (obs_q.size() != 0) void'(obs_q.pop_front());
        @(negedge clk);
        run_pair("tie", 1, 32'h304, 32'h308);
    endtask

    task automatic test_reset_mid_d();
        cmd_t e;
        wait_n = 6;
        e = mk_d(4'b1000, 3'd0, 32'h400, 32'd0);
        bus.dread = 4'b1000; bus.daddr = 32'h400; bus.dwdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_drdata = '0;
        exp_irdata = '0;
        model_last_d = 1'b0;
        n_cmp++; if (bus.mread !== 4'd0 || bus.maddr !== 32'd0) begin n_err++;
            $display("FAIL rst_mid_mcmd: mread=%h maddr=%h, want 0/0", bus.mread, bus.maddr); end
        n_cmp++; if (bus.drdata !== exp_drdata || bus.irdata !== exp_irdata) begin n_err++;
            $display("FAIL rst_mid_rdata: drdata=%h irdata=%h, want 0/0", bus.drdata, bus.irdata); end
        n_cmp++; if (bus.dbusywait !== 1'b1) begin n_err++;
            $display("FAIL rst_mid_dbw: dbw=%b, want 1", bus.dbusywait); end
        bus.dread = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.drdata !== exp_drdata || bus.mread !== 4'd0) begin n_err++;
            $display("FAIL rst_mid_after: drdata=%h mread=%h, want 0/0", bus.drdata, bus.mread); end
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== e) begin n_err++;
            $display("FAIL rst_mid_cmds: seen=%0d, want 1 command %h", obs_q.size(), e); end
        obs_q.delete();
    endtask

    task automatic test_drop_i();
        int hi, found;
        cmd_t e;
        wait_n = 3;
        e = mk_i(32'h80);
        exp_irdata = rd_val(32'h80);
        bus.iread = 1'b1; bus.iaddr = 32'h80;
        repeat (2) @(negedge clk);
        bus.iread = 1'b0;
        #1;
        n_cmp++; if (bus.ibusywait !== 1'b0) begin n_err++;
            $display("FAIL drop_ibw: ibw=%b, want 0", bus.ibusywait); end
        found = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.irdata === exp_irdata) begin found = k; break; end
        end
        n_cmp++; if (found !== 2) begin n_err++;
            $display("FAIL drop_capture: irdata=%h after %0d cycles, want %h after 2",
                     bus.irdata, found, exp_irdata); end
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== e) begin n_err++;
            $display("FAIL drop_cmd: seen=%0d, want 1 command %h", obs_q.size(), e); end
        obs_q.delete();
        @(negedge clk);
        n_cmp++; if (bus.mread !== 4'd0) begin n_err++;
            $display("FAIL drop_idle: mread=%h, want 0", bus.mread); end
        wait_n = 0;
        model_last_d = 1'b0;
        drive_d(4'b0001, 3'd0, 32'h88, 32'd0, hi);
        exp_drdata = rd_val(32'h88);
        model_last_d = 1'b1;
        n_cmp++; if (hi !== 1 || bus.drdata !== exp_drdata) begin n_err++;
            $display("FAIL drop_next: busy cycles=%0d drdata=%h, want 1/%h", hi, bus.drdata, exp_drdata); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_store();
        test_simultaneous();
        test_back_to_back();
        test_tie_after_d();
        test_reset_mid_d();
        test_drop_i();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
